uart_rx: RTL and testbench
==========================

# uart_rx

UART receiver that deserialises an asynchronous 8N1 serial line into parallel words and pushes each valid word into the downstream `fifo` through its `write`/`write_data` port. It is the stage directly upstream of `uart0_fifo`: `write` and `write_data` connect one-to-one to the FIFO's `write` and `write_data`, with matching `bit_width`. Framing errors and start-bit glitches are rejected and never reach the FIFO.

## Interface

- `clocks_per_bit`, default 217: clk cycles per serial bit (25 MHz / 115200). Must be ≥ 4.
- `bit_width`, default 8: data bits per frame. Must equal the downstream FIFO's `bit_width`.

- `clk`  input  1  system clock; the only clock.
- `rst`  input  1  synchronous, active-high reset.
- `rxd`  input  1  asynchronous serial line; idle high.
- `write`  output  1  one-cycle push strobe to the FIFO.
- `write_data`  output  `bit_width`  received word; valid while `write` is high.
- `frame_error`  output  1  one-cycle pulse when the stop bit samples low.
- `busy`  output  1  high while a frame is being received.

## Operation

- `rxd` passes through a 2-flop synchroniser, giving `rxd_s`. Both flops reset to 1. All logic uses `rxd_s`.
- The bit counter is `$clog2(clocks_per_bit)` bits wide. The data shift register is `bit_width` bits wide and shifts in LSB first.
- States and transitions:
  - IDLE: `busy`=0. On `rxd_s`==0, go to START and load the counter with half = `clocks_per_bit`/2 (integer division).
  - START: when the counter expires, sample `rxd_s`.
    - If 0: go to DATA, reload `clocks_per_bit`.
    - If 1: treat as a glitch and return to IDLE. No output is produced.
  - DATA: at each expiry, sample one bit into the shift register and reload. After `bit_width` samples, go to STOP.
  - STOP: at expiry, sample `rxd_s`.
    - If 1: pulse `write` and go to IDLE.
    - If 0: pulse `frame_error` and go to BREAK.
  - BREAK: wait until `rxd_s`==1, then go to IDLE. This prevents a held-low line from being read as back-to-back frames.
- `busy` is high in START, DATA, STOP and BREAK.
- `write_data` updates only in the cycle `write` is asserted and holds its value otherwise.
- There is no backpressure. The FIFO's full handling is the FIFO's responsibility.
- Reset mid-frame aborts the frame immediately and returns to IDLE. No `write` or `frame_error` is issued for the aborted frame.

## Timing

- Reset values: `write`=0, `write_data`=0, `frame_error`=0, `busy`=0, state IDLE.
- Let t0 be the first cycle in which IDLE sees `rxd_s`==0 (2 cycles after the pin falls).
- Start-bit sample: t0 + half.
- Data bit i (i = 0..`bit_width`-1) sample: t0 + half + (i+1)·`clocks_per_bit`.
- Stop sample: t0 + half + (`bit_width`+1)·`clocks_per_bit`.
- `write` or `frame_error` is registered: high in the cycle after the stop sample, for exactly 1 cycle.
- Back-to-back frames: IDLE is re-entered mid stop bit. The next start edge is detected with no idle gap required.
- `write` and `frame_error` are never high in the same cycle.

## Test plan

Run with `clocks_per_bit`=16 and `bit_width`=8 (half = 8), `write`/`write_data` wired to a `fifo` instance.

- **Single frame:** drive 8N1 frame 0xA5 → exactly one `write` pulse at t0+8+144+1 with `write_data`=0xA5. `frame_error` stays 0. `busy` returns to 0; the FIFO read then yields 0xA5.
- **Start glitch:** hold `rxd` low for 4 cycles, then high → `busy` high until t0+8, then 0. No `write`, no `frame_error`.
- **Framing error:** drive 0x3C with the stop bit held low for 3 bit times, then high → one `frame_error` pulse, no `write`. No new frame starts until `rxd` goes high. A following 0x5A is received correctly.
- **Back-to-back:** drive 0x01 then 0xFF with zero idle bits between them → two `write` pulses, 160 cycles apart, carrying 0x01 then 0xFF.
- **Reset mid-frame:** assert `rst` for 1 cycle during data bit 4 of 0x77 → all outputs read their reset values the next cycle, with no `write`. The next frame 0x42 yields `write_data`=0x42.
- **Line held low after reset:** release `rst` with `rxd`=0 → the receiver enters START and detects a frame. The bench checks `frame_error` after the stop sample and that no `write` occurs.

Source files
------------

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
//
// Purpose:
//   8N1 UART receiver. It deserialises an asynchronous serial line into
//   bit_width-bit words and pushes each good word downstream with a
//   one-cycle write strobe. A stop bit that samples low does not produce a
//   word. Instead it raises a one-cycle frame_error pulse and the receiver
//   waits for the line to return high. A start bit that is not still low
//   at its mid-point counts as a glitch and is dropped silently.
//
// Parameters:
//   clocks_per_bit - clk cycles per serial bit (>= 4)
//   bit_width      - data bits per frame (matches the downstream FIFO)
//
// Ports:
//   clk          in   system clock, the only clock
//   rst          in   synchronous active-high reset
//   rxd          in   asynchronous serial line, idle high
//   write        out  one-cycle push strobe towards the FIFO
//   write_data   out  received word, valid while write is high, held after
//   frame_error  out  one-cycle pulse when the stop bit samples low
//   busy         out  high while a frame (or a post-error break) is active
// ---------------------------------------------------------------------------
module uart_rx #(
    parameter int unsigned clocks_per_bit = 217,
    parameter int unsigned bit_width      = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    output logic                 write,
    output logic [bit_width-1:0] write_data,
    output logic                 frame_error,
    output logic                 busy
);

    // The bit timer counts down to zero, so it only has to hold
    // clocks_per_bit-1. That fits in $clog2(clocks_per_bit) bits.
    localparam int unsigned CntW = $clog2(clocks_per_bit);
    localparam int unsigned IdxW = (bit_width > 1) ? $clog2(bit_width) : 1;

    // Reload values are one less than the wanted interval. This is because
    // the expiry cycle itself is the cycle in which the counter reads zero.
    localparam logic [CntW-1:0] HalfLoad = CntW'(clocks_per_bit / 2 - 1);
    localparam logic [CntW-1:0] BitLoad  = CntW'(clocks_per_bit - 1);
    localparam logic [IdxW-1:0] LastIdx  = IdxW'(bit_width - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } state_e;

    logic                 rxdMeta_q;
    logic                 rxdSync_q;
    state_e               state_q;
    logic [CntW-1:0]      bitCnt_q;
    logic [IdxW-1:0]      bitIdx_q;
    logic [bit_width-1:0] shift_q;
    logic [bit_width-1:0] shift_d;
    logic                 write_q;
    logic [bit_width-1:0] writeData_q;
    logic                 frameError_q;
    logic                 busy_q;

    // Two-flop synchroniser for the asynchronous line. Both flops reset to
    // the idle (high) level. This keeps a reset from looking like a start
    // edge unless the pin really is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            rxdMeta_q <= 1'b1;
            rxdSync_q <= 1'b1;
        end else begin
            rxdMeta_q <= rxd;
            rxdSync_q <= rxdMeta_q;
        end
    end

    // Next value of the data shift register. Bits arrive LSB first, so each
    // new sample enters at the top and older bits move down towards bit 0.
    // After bit_width samples the first bit received sits in bit 0.
    always_comb begin
        shift_d                = shift_q >> 1;
        shift_d[bit_width-1]   = rxdSync_q;
    end

    // Receive state machine. All outputs are registered here, so write,
    // frame_error and busy are glitch-free. The strobes are cleared by
    // default and raised for a single cycle only. A synchronous reset
    // abandons any frame in progress without emitting anything for it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            bitCnt_q     <= '0;
            bitIdx_q     <= '0;
            shift_q      <= '0;
            write_q      <= 1'b0;
            writeData_q  <= '0;
            frameError_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            write_q      <= 1'b0;
            frameError_q <= 1'b0;

            case (state_q)
                StIdle: begin
                    // A low line is a candidate start bit. Time half a bit
                    // so that all later samples land mid-bit.
                    if (!rxdSync_q) begin
                        state_q  <= StStart;
                        bitCnt_q <= HalfLoad;
                        busy_q   <= 1'b1;
                    end
                end

                StStart: begin
                    if (bitCnt_q == '0) begin
                        if (!rxdSync_q) begin
                            state_q  <= StData;
                            bitCnt_q <= BitLoad;
                            bitIdx_q <= '0;
                        end else begin
                            // The line bounced back high before mid-start:
                            // a glitch, not a frame.
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        bitCnt_q <= bitCnt_q - CntW'(1);
                    end
                end

                StData: begin
                    if (bitCnt_q == '0) begin
                        shift_q  <= shift_d;
                        bitCnt_q <= BitLoad;
                        if (bitIdx_q == LastIdx) begin
                            state_q <= StStop;
                        end else begin
                            bitIdx_q <= bitIdx_q + IdxW'(1);
                        end
                    end else begin
                        bitCnt_q <= bitCnt_q - CntW'(1);
                    end
                end

                StStop: begin
                    if (bitCnt_q == '0) begin
                        if (rxdSync_q) begin
                            // A good frame. Return to idle mid stop bit, so
                            // a start edge right after the stop bit is seen.
                            write_q     <= 1'b1;
                            writeData_q <= shift_q;
                            state_q     <= StIdle;
                            busy_q      <= 1'b0;
                        end else begin
                            frameError_q <= 1'b1;
                            state_q      <= StBreak;
                        end
                    end else begin
                        bitCnt_q <= bitCnt_q - CntW'(1);
                    end
                end

                StBreak: begin
                    // Hold off until the line goes high again. Otherwise a
                    // line held low would be read as an endless run of
                    // zero frames.
                    if (rxdSync_q) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                end

                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign write       = write_q;
    assign write_data  = writeData_q;
    assign frame_error = frameError_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
//
// Self-checking bench for uart_rx with clocks_per_bit = 16 and bit_width = 8.
// A negedge monitor logs every write (with its data), every frame_error
// pulse and busy in every cycle. A queue stands in for the downstream FIFO.
// Expected event cycles come from the frame timing. If the pin falls in
// cycle f, the write or frame_error pulse lands at f + LAT. busy is high
// from f+3 to f+LAT-1 for a good frame.
// ---------------------------------------------------------------------------
module tb_uart_rx;

    localparam int CPB  = 16;
    localparam int W    = 8;
    localparam int HALF = CPB / 2;
    localparam int LAT  = 2 + HALF + (W + 1) * CPB + 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         rxd = 1'b1;
    logic         write;
    logic [W-1:0] write_data;
    logic         frame_error;
    logic         busy;

    uart_rx #(
        .clocks_per_bit(CPB),
        .bit_width     (W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rxd        (rxd),
        .write      (write),
        .write_data (write_data),
        .frame_error(frame_error),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nChecks = 0;
    int nFails  = 0;

    int           wrCyc[$];
    logic [W-1:0] wrData[$];
    int           feCyc[$];
    logic [W-1:0] fifoQ[$];
    bit           busyLog[int];

    // Monitor: log the events and check that write and frame_error never
    // fire in the same cycle.
    always @(negedge clk) begin
        busyLog[cyc] = busy;
        if (write === 1'b1) begin
            wrCyc.push_back(cyc);
            wrData.push_back(write_data);
            fifoQ.push_back(write_data);
        end
        if (frame_error === 1'b1) feCyc.push_back(cyc);
        nChecks++;
        if (write === 1'b1 && frame_error === 1'b1) begin
            nFails++;
            $display("[TB] FAIL exclusive_strobes at cycle %0d: write=%b frame_error=%b, required not both high",
                     cyc, write, frame_error);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clearLogs();
        wrCyc.delete();
        wrData.delete();
        feCyc.delete();
        fifoQ.delete();
    endtask

    // Drive one 8N1 frame on the pin. The stop level and its length are
    // configurable, and the line is returned high afterwards. fall is the
    // cycle in which the pin went low.
    task automatic applyStimulus(input logic [W-1:0] d, input logic stopLevel,
                                 input int stopCycles, output int fall);
        fall = cyc;
        rxd  = 1'b0;
        waitCycles(CPB);
        for (int i = 0; i < W; i++) begin
            rxd = d[i];
            waitCycles(CPB);
        end
        rxd = stopLevel;
        waitCycles(stopCycles);
        rxd = 1'b1;
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stopLevel;
        int         stopCycles;
        int         expWrites;
        int         expFe;
    } vec_t;

    vec_t         vecs[6];
    int           fall;
    int           fall2;
    int           rel;
    int           rFalls[$];
    logic [W-1:0] rData[$];
    logic [W-1:0] popped;
    logic [W-1:0] rd;
    int           gap;

    initial begin
        vecs[0] = '{8'hA5, 1'b1, CPB,     1, 0};
        vecs[1] = '{8'h00, 1'b1, CPB,     1, 0};
        vecs[2] = '{8'hFF, 1'b1, CPB,     1, 0};
        vecs[3] = '{8'h3C, 1'b0, 3 * CPB, 0, 1};
        vecs[4] = '{8'h5A, 1'b1, CPB,     1, 0};
        vecs[5] = '{8'h81, 1'b1, CPB,     1, 0};

        // Reset state.
        waitCycles(3);
        checkOutput("reset_write",       32'(write),       32'd0);
        checkOutput("reset_write_data",  32'(write_data),  32'd0);
        checkOutput("reset_frame_error", 32'(frame_error), 32'd0);
        checkOutput("reset_busy",        32'(busy),        32'd0);
        rst = 1'b0;
        waitCycles(5);

        // Table-driven single frames, including a framing error followed by
        // a good frame.
        for (int k = 0; k < 6; k++) begin
            clearLogs();
            applyStimulus(vecs[k].data, vecs[k].stopLevel, vecs[k].stopCycles, fall);
            waitCycles(60);
            checkOutput("vec_write_count", 32'(wrCyc.size()), 32'(vecs[k].expWrites));
            checkOutput("vec_fe_count",    32'(feCyc.size()), 32'(vecs[k].expFe));
            checkOutput("vec_busy_last_stop", 32'(busyLog[fall + LAT - 1]), 32'd1);
            if (vecs[k].expWrites == 1) begin
                checkOutput("vec_write_cycle", (wrCyc.size() > 0) ? 32'(wrCyc[0]) : 32'hFFFF_FFFF,
                            32'(fall + LAT));
                checkOutput("vec_write_data", (wrData.size() > 0) ? 32'(wrData[0]) : 32'hFFFF_FFFF,
                            32'(vecs[k].data));
                popped = (fifoQ.size() > 0) ? fifoQ.pop_front() : 'x;
                checkOutput("vec_fifo_read", 32'(popped), 32'(vecs[k].data));
                checkOutput("vec_data_hold", 32'(write_data), 32'(vecs[k].data));
                checkOutput("vec_busy_after_stop", 32'(busyLog[fall + LAT]), 32'd0);
            end else begin
                checkOutput("vec_fe_cycle", (feCyc.size() > 0) ? 32'(feCyc[0]) : 32'hFFFF_FFFF,
                            32'(fall + LAT));
                checkOutput("vec_busy_in_break", 32'(busyLog[fall + 193]), 32'd1);
                checkOutput("vec_busy_after_break", 32'(busyLog[fall + 200]), 32'd0);
            end
            checkOutput("vec_busy_end", 32'(busy), 32'd0);
        end

        // Start glitch: four low cycles, then high again.
        clearLogs();
        fall = cyc;
        rxd  = 1'b0;
        waitCycles(4);
        rxd = 1'b1;
        waitCycles(40);
        checkOutput("glitch_busy_first", 32'(busyLog[fall + 3]),  32'd1);
        checkOutput("glitch_busy_t0p8",  32'(busyLog[fall + 10]), 32'd1);
        checkOutput("glitch_busy_drop",  32'(busyLog[fall + 11]), 32'd0);
        checkOutput("glitch_no_write",   32'(wrCyc.size()), 32'd0);
        checkOutput("glitch_no_fe",      32'(feCyc.size()), 32'd0);

        // Back-to-back frames with no idle time between them.
        clearLogs();
        applyStimulus(8'h01, 1'b1, CPB, fall);
        applyStimulus(8'hFF, 1'b1, CPB, fall2);
        waitCycles(30);
        checkOutput("b2b_count", 32'(wrCyc.size()), 32'd2);
        if (wrCyc.size() == 2) begin
            checkOutput("b2b_first_cycle", 32'(wrCyc[0]), 32'(fall + LAT));
            checkOutput("b2b_spacing",     32'(wrCyc[1] - wrCyc[0]), 32'd160);
            checkOutput("b2b_data0",       32'(wrData[0]), 32'h01);
            checkOutput("b2b_data1",       32'(wrData[1]), 32'hFF);
        end

        // Reset pulse during data bit 4 of 0x77.
        clearLogs();
        rxd = 1'b0;
        waitCycles(CPB);
        for (int i = 0; i < 4; i++) begin
            rd  = 8'h77;
            rxd = rd[i];
            waitCycles(CPB);
        end
        rxd = 1'b1;
        waitCycles(8);
        rst = 1'b1;
        waitCycles(1);
        rst = 1'b0;
        checkOutput("midrst_write",       32'(write),       32'd0);
        checkOutput("midrst_write_data",  32'(write_data),  32'd0);
        checkOutput("midrst_frame_error", 32'(frame_error), 32'd0);
        checkOutput("midrst_busy",        32'(busy),        32'd0);
        waitCycles(200);
        checkOutput("midrst_no_write", 32'(wrCyc.size()), 32'd0);
        checkOutput("midrst_no_fe",    32'(feCyc.size()), 32'd0);
        applyStimulus(8'h42, 1'b1, CPB, fall);
        waitCycles(20);
        checkOutput("midrst_next_data", (wrData.size() > 0) ? 32'(wrData[0]) : 32'hFFFF_FFFF, 32'h42);

        // Line held low while reset is released.
        rst = 1'b1;
        rxd = 1'b0;
        waitCycles(3);
        clearLogs();
        rst = 1'b0;
        rel = cyc;
        waitCycles(LAT + 20);
        checkOutput("low_fe_count", 32'(feCyc.size()), 32'd1);
        checkOutput("low_fe_cycle", (feCyc.size() > 0) ? 32'(feCyc[0]) : 32'hFFFF_FFFF, 32'(rel + LAT));
        checkOutput("low_busy_break", 32'(busyLog[rel + LAT + 10]), 32'd1);
        rxd = 1'b1;
        waitCycles(20);
        checkOutput("low_busy_end", 32'(busy), 32'd0);
        checkOutput("low_no_write", 32'(wrCyc.size()), 32'd0);

        // Randomised stream of good frames against the timing model.
        clearLogs();
        rFalls.delete();
        rData.delete();
        for (int n = 0; n < 16; n++) begin
            gap = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 40));
            waitCycles(gap);
            rd = W'($urandom);
            applyStimulus(rd, 1'b1, CPB, fall);
            rFalls.push_back(fall);
            rData.push_back(rd);
        end
        waitCycles(40);
        checkOutput("rand_count", 32'(wrCyc.size()), 32'(rFalls.size()));
        for (int n = 0; n < rFalls.size(); n++) begin
            checkOutput("rand_cycle", (n < wrCyc.size()) ? 32'(wrCyc[n]) : 32'hFFFF_FFFF,
                        32'(rFalls[n] + LAT));
            checkOutput("rand_data", (n < wrData.size()) ? 32'(wrData[n]) : 32'hFFFF_FFFF,
                        32'(rData[n]));
            checkOutput("rand_busy_pre",  32'(busyLog[rFalls[n] + 2]),       32'd0);
            checkOutput("rand_busy_on",   32'(busyLog[rFalls[n] + 3]),       32'd1);
            checkOutput("rand_busy_stop", 32'(busyLog[rFalls[n] + LAT - 1]), 32'd1);
            checkOutput("rand_busy_off",  32'(busyLog[rFalls[n] + LAT]),     32'd0);
        end
        checkOutput("rand_no_fe", 32'(feCyc.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
